// File: rtl/vga_scan_gen.sv
// Raster scan generator: walks the frame one pixel per pix_en and presents a
// registered position together with syncs, video_on, tile fields and strobes.
module vga_scan_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter int unsigned CLK_DIV     = 1,
  parameter int unsigned TILE_SHIFT  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  output logic       pix_en,
  output logic [9:0] global_pixel_x,
  output logic [9:0] global_pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic [4:0] tile_col,
  output logic [4:0] tile_row,
  output logic [4:0] local_x,
  output logic [4:0] local_y,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic [9:0] LOC_MASK = 10'((1 << TILE_SHIFT) - 1);

  logic [2:0] div_cnt_q, div_cnt_d;
  logic       started_q, started_d;
  logic       pix_en_q, pix_en_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       video_on_q, video_on_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_tick_q, line_tick_d;
  logic       frame_tick_q, frame_tick_d;
  logic       div_hit;
  logic [9:0] x_shr, y_shr;

  // Next-state: divider, scan position and decoded outputs for the new pixel.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    started_d    = started_q;
    pix_en_d     = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    video_on_d   = video_on_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    line_tick_d  = 1'b0;
    frame_tick_d = 1'b0;
    div_hit      = (div_cnt_q >= DIV_LAST);

    if (scan_en) begin
      div_cnt_d = div_hit ? 3'd0 : div_cnt_q + 3'd1;
      if (div_hit) begin
        pix_en_d = 1'b1;
        if (!started_q) begin
          // First pixel after reset presents (0,0) without advancing.
          started_d = 1'b1;
          x_d       = 10'd0;
          y_d       = 10'd0;
        end else if (x_q >= H_LAST) begin
          // >= keeps the counters in range even if they were ever out of it.
          x_d         = 10'd0;
          line_tick_d = 1'b1;
          if (y_q >= V_LAST) begin
            y_d          = 10'd0;
            frame_tick_d = 1'b1;
          end else begin
            y_d = y_q + 10'd1;
          end
        end else begin
          x_d = x_q + 10'd1;
        end
        video_on_d = (x_d < H_ACT) && (y_d < V_ACT);
        hsync_d    = ((x_d >= HS_START) && (x_d < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d    = ((y_d >= VS_START) && (y_d < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      end
    end
  end

  // State register with synchronous reset taking priority over scan_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= 3'd0;
      started_q    <= 1'b0;
      pix_en_q     <= 1'b0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      video_on_q   <= 1'b0;
      hsync_q      <= ~SYNC_ACTIVE;
      vsync_q      <= ~SYNC_ACTIVE;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      started_q    <= started_d;
      pix_en_q     <= pix_en_d;
      x_q          <= x_d;
      y_q          <= y_d;
      video_on_q   <= video_on_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Tile fields are plain slices of the registered position.
  always_comb begin
    x_shr    = x_q >> TILE_SHIFT;
    y_shr    = y_q >> TILE_SHIFT;
    tile_col = x_shr[4:0];
    tile_row = y_shr[4:0];
    local_x  = 5'(x_q & LOC_MASK);
    local_y  = 5'(y_q & LOC_MASK);
  end

  assign pix_en         = pix_en_q;
  assign global_pixel_x = x_q;
  assign global_pixel_y = y_q;
  assign video_on       = video_on_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign line_tick      = line_tick_q;
  assign frame_tick     = frame_tick_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: default 640x480 timing at CLK_DIV 1 and 4,
// plus a shrunken frame (128x79 total) so frame-level behaviour fits a short run.
module tb_vga_scan_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // DUT a: default timing, CLK_DIV = 1
  logic rst_a = 1'b1, en_a = 1'b1;
  logic pix_a, von_a, hs_a, vs_a, lt_a, ft_a;
  logic [9:0] gx_a, gy_a;
  logic [4:0] tc_a, tr_a, lx_a, ly_a;
  vga_scan_gen u_dut_a (
    .clk(clk), .reset(rst_a), .scan_en(en_a), .pix_en(pix_a),
    .global_pixel_x(gx_a), .global_pixel_y(gy_a), .video_on(von_a),
    .hsync(hs_a), .vsync(vs_a), .tile_col(tc_a), .tile_row(tr_a),
    .local_x(lx_a), .local_y(ly_a), .line_tick(lt_a), .frame_tick(ft_a)
  );

  // DUT b: default timing, CLK_DIV = 4
  logic rst_b = 1'b1, en_b = 1'b1;
  logic pix_b, von_b, hs_b, vs_b, lt_b, ft_b;
  logic [9:0] gx_b, gy_b;
  logic [4:0] tc_b, tr_b, lx_b, ly_b;
  vga_scan_gen #(.CLK_DIV(4)) u_dut_b (
    .clk(clk), .reset(rst_b), .scan_en(en_b), .pix_en(pix_b),
    .global_pixel_x(gx_b), .global_pixel_y(gy_b), .video_on(von_b),
    .hsync(hs_b), .vsync(vs_b), .tile_col(tc_b), .tile_row(tr_b),
    .local_x(lx_b), .local_y(ly_b), .line_tick(lt_b), .frame_tick(ft_b)
  );

  // DUT c: 112+4+8+4 = 128 by 72+2+2+3 = 79, CLK_DIV = 1
  logic rst_c = 1'b1, en_c = 1'b1;
  logic pix_c, von_c, hs_c, vs_c, lt_c, ft_c;
  logic [9:0] gx_c, gy_c;
  logic [4:0] tc_c, tr_c, lx_c, ly_c;
  vga_scan_gen #(
    .H_ACTIVE(112), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(72), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_c (
    .clk(clk), .reset(rst_c), .scan_en(en_c), .pix_en(pix_c),
    .global_pixel_x(gx_c), .global_pixel_y(gy_c), .video_on(von_c),
    .hsync(hs_c), .vsync(vs_c), .tile_col(tc_c), .tile_row(tr_c),
    .local_x(lx_c), .local_y(ly_c), .line_tick(lt_c), .frame_tick(ft_c)
  );

  initial begin
    int von_cnt, hs_lo_cnt, hs_min, hs_max, lt_cnt, pos_bad;
    int first_pix, last_pix, pix_cnt, gap_bad, adv_bad, lt_step;
    int vs_lo_cnt, ft_cnt, ft_idx, hold_bad;
    int prev_x;

    // Reset held 3 clocks
    for (int i = 0; i < 3; i++) step();
    check("rst_pix", int'(pix_a), 0);
    check("rst_x", int'(gx_a), 0);
    check("rst_y", int'(gy_a), 0);
    check("rst_von", int'(von_a), 0);
    check("rst_hs", int'(hs_a), 1);
    check("rst_vs", int'(vs_a), 1);
    check("rst_ticks", int'({lt_a, ft_a}), 0);
    check("rst_tiles", int'({tc_a, tr_a, lx_a, ly_a}), 0);
    check("rst_b_pix", int'(pix_b), 0);

    // One full line on DUT a, plus the first pixel of the next
    rst_a = 1'b0;
    von_cnt = 0; hs_lo_cnt = 0; hs_min = 9999; hs_max = -1; lt_cnt = 0; pos_bad = 0;
    for (int i = 0; i <= 800; i++) begin
      step();
      if (i == 0) begin
        check("first_pix", int'(pix_a), 1);
        check("first_xy", int'({gx_a, gy_a}), 0);
        check("first_von", int'(von_a), 1);
        check("first_syncs", int'({hs_a, vs_a}), 3);
        check("first_ticks", int'({lt_a, ft_a}), 0);
      end
      if (i == 1) check("second_x", int'(gx_a), 1);
      if (int'(gx_a) != i % 800 || int'(gy_a) != i / 800 || !pix_a) pos_bad++;
      if (i < 800) begin
        if (von_a) von_cnt++;
        if (int'(von_a) != int'(i < 640)) pos_bad++;
        if (!hs_a) begin
          hs_lo_cnt++;
          if (i < hs_min) hs_min = i;
          if (i > hs_max) hs_max = i;
        end
      end
      if (lt_a) lt_cnt++;
      if (i == 800) begin
        check("wrap_lt", int'(lt_a), 1);
        check("wrap_ft", int'(ft_a), 0);
        check("wrap_y", int'(gy_a), 1);
      end
    end
    check("line_pos_bad", pos_bad, 0);
    check("line_von_cnt", von_cnt, 640);
    check("line_hs_cnt", hs_lo_cnt, 96);
    check("line_hs_min", hs_min, 656);
    check("line_hs_max", hs_max, 751);
    check("line_lt_cnt", lt_cnt, 1);

    // CLK_DIV = 4 on DUT b
    rst_b = 1'b0;
    first_pix = -1; last_pix = -1; pix_cnt = 0; gap_bad = 0; adv_bad = 0; lt_step = -1;
    prev_x = int'(gx_b);
    for (int j = 1; j <= 3204; j++) begin
      step();
      if (pix_b) begin
        if (last_pix >= 0 && j - last_pix != 4) gap_bad++;
        if (first_pix < 0) first_pix = j;
        last_pix = j;
        pix_cnt++;
      end else if (int'(gx_b) != prev_x) begin
        adv_bad++;
      end
      if (lt_b) lt_step = j;
      prev_x = int'(gx_b);
    end
    check("div4_first", first_pix, 4);
    check("div4_count", pix_cnt, 801);
    check("div4_gap", gap_bad, 0);
    check("div4_adv", adv_bad, 0);
    check("div4_line_clks", lt_step - first_pix, 3200);
    check("div4_xy", int'({gx_b, gy_b}), 1);

    // Full shrunken frame on DUT c: 128*79 = 10112 pixels
    rst_c = 1'b0;
    step();
    check("c_first_xy", int'({pix_c, gx_c, gy_c}), 1 << 20);
    vs_lo_cnt = 0; ft_cnt = 0; ft_idx = -1;
    for (int n = 1; n <= 10112; n++) begin
      step();
      if (!vs_c) vs_lo_cnt++;
      if (ft_c) begin
        ft_cnt++;
        ft_idx = n;
      end
      if (n == 9060) begin
        check("tile_xy", int'({gx_c, gy_c}), (100 << 10) | 70);
        check("tile_col", int'(tc_c), 3);
        check("tile_row", int'(tr_c), 2);
        check("local_x", int'(lx_c), 4);
        check("local_y", int'(ly_c), 6);
        check("tile_von", int'(von_c), 1);
      end
    end
    check("frame_vs_cnt", vs_lo_cnt, 256);
    check("frame_ft_cnt", ft_cnt, 1);
    check("frame_ft_idx", ft_idx, 10112);
    check("frame_wrap", int'({lt_c, gx_c, gy_c}), 1 << 20);

    // Walk to the last pixel (127,78), then pause scanning for 10 clocks
    for (int n = 0; n < 10111; n++) step();
    check("pre_pause_xy", int'({gx_c, gy_c}), (127 << 10) | 78);
    en_c = 1'b0;
    hold_bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (pix_c || lt_c || ft_c) hold_bad++;
      if (gx_c != 10'd127 || gy_c != 10'd78 || von_c || !hs_c || !vs_c) hold_bad++;
      if (tc_c != 5'd3 || lx_c != 5'd31 || tr_c != 5'd2 || ly_c != 5'd14) hold_bad++;
    end
    check("pause_hold", hold_bad, 0);
    en_c = 1'b1;
    step();
    check("resume_pix", int'(pix_c), 1);
    check("resume_xy", int'({gx_c, gy_c}), 0);
    check("resume_ticks", int'({lt_c, ft_c}), 3);
    check("resume_von", int'(von_c), 1);

    // Mid-frame reset at (60,50)
    for (int n = 0; n < 6460; n++) step();
    check("pre_reset_xy", int'({gx_c, gy_c}), (60 << 10) | 50);
    rst_c = 1'b1;
    step();
    check("mid_rst_xy", int'({gx_c, gy_c}), 0);
    check("mid_rst_flags", int'({pix_c, von_c, lt_c, ft_c}), 0);
    check("mid_rst_syncs", int'({hs_c, vs_c}), 3);
    rst_c = 1'b0;
    step();
    check("restart_pix", int'(pix_c), 1);
    check("restart_xy", int'({gx_c, gy_c}), 0);
    check("restart_ticks", int'({lt_c, ft_c}), 0);
    step();
    check("restart_x1", int'({gx_c, lt_c}), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Raster scan generator and the producing end of the global-pixel interface.
- Walks the 640x480@60 frame and drives `global_pixel_x`/`global_pixel_y` together with hsync, vsync, video_on, and line/frame strobes.
- Also drives 32x32 tile coordinates and tile-local pixel offsets, so downstream sprite/background lookups see a consistent, registered position.
- Sits between the board clock and every pixel-consuming object/renderer block.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
- CLK_DIV, 1, clk cycles per pixel (1..8); pixel enable fires once every CLK_DIV clocks
- TILE_SHIFT, 5, log2 of tile edge (32 px)

Ports:
- clk  in  1  system clock (25 MHz on board)
- reset  in  1  synchronous, active-high reset
- scan_en  in  1  1 = scanning runs; 0 = freeze all counters and outputs
- pix_en  out  1  one-clk pulse marking each new pixel
- global_pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- global_pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- video_on  out  1  1 when x < H_ACTIVE and y < V_ACTIVE
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- tile_col  out  5  global_pixel_x >> TILE_SHIFT
- tile_row  out  5  global_pixel_y >> TILE_SHIFT
- local_x  out  5  global_pixel_x[TILE_SHIFT-1:0]
- local_y  out  5  global_pixel_y[TILE_SHIFT-1:0]
- line_tick  out  1  one-clk pulse on the pix_en where x wraps to 0
- frame_tick  out  1  one-clk pulse on the pix_en where (x,y) wraps to (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- One clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset value of every output:
  - pix_en = 0, line_tick = 0, frame_tick = 0
  - global_pixel_x = global_pixel_y = 0
  - tile_col = tile_row = local_x = local_y = 0
  - video_on = 0
  - hsync = vsync = ~SYNC_ACTIVE
  - Internal divider counter = 0; internal started flag = 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while scan_en = 1.
  - pix_en is registered high for the one clk in which div_cnt == CLK_DIV-1.
  - With CLK_DIV = 1, pix_en is high every clk after reset release, provided scan_en = 1.
- Scan counters (advance only on the clk where pix_en is issued):
  - First pix_en after reset: started flag set, position presented = (0,0); counters do not advance.
  - Later pix_en with x < H_TOTAL-1: x+1.
  - x == H_TOTAL-1: x = 0, line_tick = 1; then y+1, or y = 0 with frame_tick = 1 if y == V_TOTAL-1.
  - line_tick and frame_tick are coincident with that pix_en and low otherwise.
- Output decoding:
  - All outputs are registered and change only in the clk where pix_en is issued; they then describe the pixel at the new (x,y).
  - video_on = started && x < H_ACTIVE && y < V_ACTIVE.
  - hsync = SYNC_ACTIVE iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync = SYNC_ACTIVE iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - tile/local fields are pure bit slices of x/y. They are valid in blanking too; consumers gate with video_on.
  - Visible tile range is col 0..19, row 0..14.
- scan_en = 0:
  - Divider and counters hold; pix_en, line_tick, frame_tick are forced to 0.
  - All other outputs hold.
  - Resuming continues from the held position with no skipped pixel.
- Reset mid-frame: takes priority over scan_en. Next state is the reset values; the frame restarts at (0,0) on the first pix_en after release.
- Widths: 10-bit counters. No counter may ever exceed TOTAL-1, even with scan_en toggled at a wrap boundary.

Test Plan:
- Reset held 3 clks, then released with scan_en = 1, CLK_DIV = 1:
  - Outputs are at reset values during reset.
  - First pix_en presents (0,0) with video_on = 1 and hsync = vsync = 1.
  - Next clk presents x = 1.
- Run one full line:
  - video_on is high exactly for x = 0..639.
  - hsync is low exactly for x = 656..751 (96 pix_en).
  - line_tick is high once, at the x = 799 -> 0 transition, with y 0 -> 1.
- Run one full frame:
  - vsync is low for y = 490..491 (1600 pix_en).
  - frame_tick fires once after 420000 pix_en, with (x,y) = (0,0).
  - Tile sample at (x,y) = (100,70): tile_col = 3, tile_row = 2, local_x = 4, local_y = 6.
- CLK_DIV = 4:
  - pix_en high on every 4th clk.
  - x advances only on those clks.
  - One line takes 3200 clks.
- Deassert scan_en at x = 799, y = 524 for 10 clks:
  - All outputs hold and no ticks fire.
  - On re-enable, the first pix_en gives (0,0) with line_tick = frame_tick = 1.
- Assert reset at (300,200) mid-frame:
  - Next clk shows reset values.
  - After release, scanning restarts at (0,0) with no stale tick.
